// File: rtl/bootrom_bus_adapter.sv
// CPU-side read adapter for the boot ROM controller: decodes and aligns addresses, issues
// fixed-latency ROM reads and answers repeated reads of the same word from a one-entry buffer.
module bootrom_bus_adapter #(
  parameter logic [31:0] ROM_BASE       = 32'hBFC0_0000,
  parameter int          ROM_SIZE_BYTES = 4096,
  parameter int          READ_LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic        flush,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy,
  output logic        rom_read_op,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data
);

  localparam int CW = $clog2(READ_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          err_q;
  logic          flush_seen;
  logic [29:0]   lat_tag;
  logic          buf_vld;
  logic [29:0]   buf_tag;
  logic [31:0]   buf_dat;

  logic [31:0]   offset;
  logic          dec_err;
  logic          hit;
  logic          wait_done;

  // Subtracting first keeps the upper-bound compare free of overflow.
  assign offset    = addr - ROM_BASE;
  assign dec_err   = (addr[1:0] != 2'b00) || (offset >= 32'(ROM_SIZE_BYTES));
  assign hit       = buf_vld && (buf_tag == addr[31:2]) && !flush;
  assign wait_done = (cnt == CW'(READ_LATENCY - 1));

  always_comb begin
    state_nxt   = state;
    ack         = 1'b0;
    err         = 1'b0;
    busy        = (state != IDLE);
    rom_read_op = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (dec_err || hit) state_nxt = RESP;
          else                state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        rom_read_op = 1'b1;
        state_nxt   = WAIT;
      end
      WAIT: begin
        if (wait_done) state_nxt = RESP;
      end
      RESP: begin
        ack       = 1'b1;
        err       = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      err_q      <= 1'b0;
      flush_seen <= 1'b0;
      lat_tag    <= '0;
      buf_vld    <= 1'b0;
      buf_tag    <= '0;
      buf_dat    <= '0;
      rdata      <= '0;
      rom_addr   <= '0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        buf_vld    <= 1'b0;
        flush_seen <= 1'b1;
      end
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req) begin
            err_q      <= dec_err;
            flush_seen <= flush;
            lat_tag    <= addr[31:2];
            if (!dec_err) begin
              if (hit) rdata    <= buf_dat;
              else     rom_addr <= offset;
            end
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (wait_done) begin
            rdata <= rom_data;
            // A flush at any point of this access keeps the result out of the buffer.
            if (!(flush_seen || flush)) begin
              buf_vld <= 1'b1;
              buf_tag <= lat_tag;
              buf_dat <= rom_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bootrom_bus_adapter.sv
// Directed bench for bootrom_bus_adapter with a fixed-latency ROM model.
module tb_bootrom_bus_adapter;

  localparam logic [31:0] BASE = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic        flush = 1'b0;
  logic        ack;
  logic [31:0] rdata;
  logic        err;
  logic        busy;
  logic        rom_read_op;
  logic [31:0] rom_addr;
  logic [31:0] rom_data = 32'hDEAD_BEEF;

  int checks = 0;
  int errors = 0;

  bootrom_bus_adapter dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .flush(flush),
    .ack(ack), .rdata(rdata), .err(err), .busy(busy),
    .rom_read_op(rom_read_op), .rom_addr(rom_addr), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] off);
    if (off == 32'h10) return 32'h3C08_BFC0;
    return {off[15:0] ^ 16'hC0DE, off[15:0]};
  endfunction

  // ROM model: data is valid only during the second WAIT cycle after read_op.
  logic        d1 = 1'b0, d2 = 1'b0;
  logic [31:0] a1 = '0, a2 = '0;
  initial begin
    forever begin
      @(negedge clk);
      rom_data = 32'hDEAD_BEEF;
      if (d2) rom_data = rom_fn(a2);
      d2 = d1;
      a2 = a1;
      d1 = rom_read_op;
      a1 = rom_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request; flush_at selects the cycle (0 = request cycle) in which flush is high.
  task automatic access(input logic [31:0] a, input int flush_at,
                        output int lat, output logic e, output logic [31:0] d,
                        output int nops, output logic [31:0] oaddr,
                        output logic busy_ok, output logic addr_ok);
    logic [31:0] a0;
    @(posedge clk); #1;
    req = 1'b1; addr = a; flush = (flush_at == 0);
    lat = -1; e = 1'bx; d = 'x; nops = 0; oaddr = 'x; busy_ok = 1'b1; addr_ok = 1'b1; a0 = '0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      req = 1'b0; flush = (flush_at == c);
      @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (rom_read_op === 1'b1) begin
        nops++;
        if (c == 1) oaddr = rom_addr;
      end
      if (c == 1) a0 = rom_addr;
      else if (rom_addr !== a0) addr_ok = 1'b0;
      if (ack === 1'b1) begin
        lat = c; e = err; d = rdata;
        break;
      end
    end
    flush = 1'b0;
  endtask

  task automatic run_chk(input string tag, input logic [31:0] off, input int flush_at,
                         input int exp_lat, input logic exp_err, input int exp_nops);
    int lat, nops;
    logic e, busy_ok, addr_ok;
    logic [31:0] d, oaddr;
    access(BASE + off, flush_at, lat, e, d, nops, oaddr, busy_ok, addr_ok);
    chk({tag, ".lat"}, lat, exp_lat);
    chk({tag, ".err"}, {31'b0, e}, {31'b0, exp_err});
    chk({tag, ".nops"}, nops, exp_nops);
    chk({tag, ".busy"}, {31'b0, busy_ok}, 32'd1);
    if (!exp_err) chk({tag, ".rdata"}, d, rom_fn(off));
    if (exp_nops == 1) begin
      chk({tag, ".rom_addr"}, oaddr, off);
      chk({tag, ".addr_stable"}, {31'b0, addr_ok}, 32'd1);
    end
  endtask

  int          acks, ops, k;
  logic        data_ok, stab;
  logic [31:0] seq_off [3];

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset.ack", {31'b0, ack}, 32'd0);
    chk("reset.err", {31'b0, err}, 32'd0);
    chk("reset.busy", {31'b0, busy}, 32'd0);
    chk("reset.read_op", {31'b0, rom_read_op}, 32'd0);
    chk("reset.rdata", rdata, 32'd0);
    chk("reset.rom_addr", rom_addr, 32'd0);

    run_chk("miss10", 32'h10, -1, 4, 1'b0, 1);
    run_chk("hit10", 32'h10, -1, 1, 1'b0, 0);
    run_chk("misalign", 32'h2, -1, 1, 1'b1, 0);
    run_chk("above", 32'h1000, -1, 1, 1'b1, 0);
    run_chk("below", 32'hFFFF_FFFC, -1, 1, 1'b1, 0);
    run_chk("hit10_after_err", 32'h10, -1, 1, 1'b0, 0);
    run_chk("last_word", 32'hFFC, -1, 4, 1'b0, 1);

    run_chk("flush_miss20", 32'h20, 2, 4, 1'b0, 1);
    run_chk("reread20", 32'h20, -1, 4, 1'b0, 1);
    run_chk("hit20", 32'h20, -1, 1, 1'b0, 0);

    // Reset during the first WAIT cycle of a miss.
    @(posedge clk); #1 req = 1'b1; addr = BASE + 32'h30;
    @(posedge clk); #1 req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_mid.ack", {31'b0, ack}, 32'd0);
    chk("rst_mid.err", {31'b0, err}, 32'd0);
    chk("rst_mid.busy", {31'b0, busy}, 32'd0);
    chk("rst_mid.read_op", {31'b0, rom_read_op}, 32'd0);
    chk("rst_mid.rdata", rdata, 32'd0);
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ack === 1'b1) acks++;
    end
    chk("rst_mid.no_ack", acks, 0);
    run_chk("after_rst10", 32'h10, -1, 4, 1'b0, 1);
    run_chk("flush_with_hit", 32'h10, 0, 4, 1'b0, 1);

    // req held high across three addresses.
    seq_off[0] = 32'h40; seq_off[1] = 32'h44; seq_off[2] = 32'h48;
    acks = 0; ops = 0; k = 0; data_ok = 1'b1; stab = 1'b1;
    @(posedge clk); #1 req = 1'b1; addr = BASE + seq_off[0];
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rom_read_op === 1'b1) ops++;
      if (busy === 1'b1 && ack !== 1'b1 && k < 3 && rom_addr !== seq_off[k]) stab = 1'b0;
      if (ack === 1'b1) begin
        acks++;
        if (k >= 3 || rdata !== rom_fn(seq_off[k])) data_ok = 1'b0;
        k++;
        if (k < 3) addr = BASE + seq_off[k];
        else req = 1'b0;
      end
    end
    req = 1'b0;
    chk("held.acks", acks, 3);
    chk("held.ops", ops, 3);
    chk("held.data", {31'b0, data_ok}, 32'd1);
    chk("held.addr_stable", {31'b0, stab}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
